// File: rtl/tlb_ctrl_if.sv
// Op request channel between the CSR/exception unit and tlb_ctrl.
// Valid/ready request in, one-cycle done/err pulses back.
interface tlb_ctrl_if;
  logic       op_valid;
  logic [2:0] op_code;
  logic       op_ready;
  logic       op_done;
  logic       op_err;

  modport master (
    output op_valid, op_code,
    input  op_ready, op_done, op_err
  );

  modport slave (
    input  op_valid, op_code,
    output op_ready, op_done, op_err
  );
endinterface

// File: rtl/tlb_ctrl.sv
// TLB op sequencer: runs TLBSRCH/RD/WR/FILL/INVTLB one at a time
// and shares TLB search port 1 with data-side translation.
module tlb_ctrl #(
  parameter int TLBNUM = 32,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  tlb_ctrl_if.slave       op,
  input  logic [18:0]     csr_vppn,
  input  logic [9:0]      csr_asid,
  input  logic [IDXW-1:0] csr_index,
  input  logic [5:0]      csr_ps,
  input  logic            csr_ne,
  input  logic            csr_tlbr,
  input  logic [31:0]     csr_elo0,
  input  logic [31:0]     csr_elo1,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vpn,
  input  logic            mem_req,
  input  logic [18:0]     mem_vppn,
  input  logic            mem_odd,
  input  logic [9:0]      mem_asid,
  output logic            mem_gnt,
  output logic            mem_rsp_valid,
  output logic            t_s1_fetch,
  output logic [18:0]     t_s1_vppn,
  output logic            t_s1_odd_page,
  output logic [9:0]      t_s1_asid,
  input  logic            t_s1_found,
  input  logic [4:0]      t_s1_index,
  output logic            t_we,
  output logic [IDXW-1:0] t_w_index,
  output logic [18:0]     t_w_vppn,
  output logic [9:0]      t_w_asid,
  output logic            t_w_g,
  output logic [5:0]      t_w_ps,
  output logic            t_w_e,
  output logic            t_w_v0,
  output logic            t_w_v1,
  output logic            t_w_d0,
  output logic            t_w_d1,
  output logic [1:0]      t_w_mat0,
  output logic [1:0]      t_w_mat1,
  output logic [1:0]      t_w_plv0,
  output logic [1:0]      t_w_plv1,
  output logic [19:0]     t_w_ppn0,
  output logic [19:0]     t_w_ppn1,
  output logic [IDXW-1:0] t_r_index,
  output logic            t_inv_en,
  output logic [4:0]      t_inv_op,
  output logic [9:0]      t_inv_asid,
  output logic [18:0]     t_inv_vpn,
  output logic            csr_srch_we,
  output logic            srch_hit,
  output logic [IDXW-1:0] srch_index,
  output logic            csr_rd_we
);

  typedef enum logic [1:0] {
    IDLE, SRCH_REQ, SRCH_RSP, EXEC
  } state_e;

  // ELO kept as {PPN, G, MAT, PLV, D, V}
  typedef struct packed {
    logic [2:0]      code;
    logic [18:0]     vppn;
    logic [9:0]      asid;
    logic [IDXW-1:0] idx;
    logic [5:0]      ps;
    logic            ne;
    logic            tlbr;
    logic [26:0]     lo0;
    logic [26:0]     lo1;
    logic [4:0]      iop;
    logic [9:0]      iasid;
    logic [18:0]     ivpn;
  } cap_t;

  state_e          state_q, state_d;
  cap_t            cap_q, cap_d;
  logic [IDXW-1:0] fill_q, fill_d;
  logic            rsp_q;

  logic accept;
  logic is_rd, is_wr, is_fill, is_inv, inv_ok;
  logic we, inv_en, rd_we, err;
  logic unused_elo;

  assign unused_elo = ^{csr_elo0[31:28], csr_elo0[7],
                        csr_elo1[31:28], csr_elo1[7]};

  assign accept  = (state_q == IDLE) & op.op_valid;
  assign is_rd   = cap_q.code == 3'd1;
  assign is_wr   = cap_q.code == 3'd2;
  assign is_fill = cap_q.code == 3'd3;
  assign is_inv  = cap_q.code == 3'd4;
  assign inv_ok  = cap_q.iop <= 5'd6;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cap_q   <= '0;
      fill_q  <= '0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      fill_q  <= fill_d;
      rsp_q   <= mem_req & mem_gnt;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (op.op_valid)
          state_d = (op.op_code == 3'd0) ? SRCH_REQ : EXEC;
      end
      SRCH_REQ: state_d = SRCH_RSP;
      SRCH_RSP: state_d = IDLE;
      EXEC:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_d = cap_q;
    if (accept) begin
      cap_d.code  = op.op_code;
      cap_d.vppn  = csr_vppn;
      cap_d.asid  = csr_asid;
      cap_d.idx   = csr_index;
      cap_d.ps    = csr_ps;
      cap_d.ne    = csr_ne;
      cap_d.tlbr  = csr_tlbr;
      cap_d.lo0   = {csr_elo0[27:8], csr_elo0[6:0]};
      cap_d.lo1   = {csr_elo1[27:8], csr_elo1[6:0]};
      cap_d.iop   = inv_op;
      cap_d.iasid = inv_asid;
      cap_d.ivpn  = inv_vpn;
    end
  end

  always_comb begin
    we     = 1'b0;
    inv_en = 1'b0;
    rd_we  = 1'b0;
    err    = 1'b0;
    if (state_q == EXEC) begin
      unique case (1'b1)
        is_rd:          rd_we = 1'b1;
        is_wr, is_fill: we    = 1'b1;
        is_inv: begin
          inv_en = inv_ok;
          err    = ~inv_ok;
        end
        default:        err   = 1'b1;
      endcase
    end
  end

  always_comb begin
    fill_d = fill_q;
    if (t_we & is_fill)
      fill_d = (fill_q == IDXW'(TLBNUM - 1)) ?
               '0 : fill_q + IDXW'(1);
  end

  // Strobes drop as soon as reset is seen so an aborted op has no effect
  assign op.op_ready = state_q == IDLE;
  assign op.op_done  = resetn &
                       ((state_q == SRCH_RSP) | (state_q == EXEC));
  assign op.op_err   = resetn & err;
  assign t_we        = resetn & we;
  assign t_inv_en    = resetn & inv_en;
  assign csr_rd_we   = resetn & rd_we;
  assign csr_srch_we = resetn & (state_q == SRCH_RSP);
  assign srch_hit    = csr_srch_we & t_s1_found;
  assign srch_index  = srch_hit ? t_s1_index[IDXW-1:0] : '0;

  assign mem_gnt       = state_q != SRCH_REQ;
  assign mem_rsp_valid = rsp_q;
  assign t_s1_fetch    = resetn & (mem_gnt ? mem_req : 1'b1);
  assign t_s1_vppn     = mem_gnt ? mem_vppn : cap_q.vppn;
  assign t_s1_asid     = mem_gnt ? mem_asid : cap_q.asid;
  assign t_s1_odd_page = mem_gnt & mem_odd;

  assign t_w_index = is_fill ? fill_q : cap_q.idx;
  assign t_w_vppn  = cap_q.vppn;
  assign t_w_asid  = cap_q.asid;
  assign t_w_ps    = cap_q.ps;
  assign t_w_e     = cap_q.tlbr | ~cap_q.ne;
  assign t_w_g     = cap_q.lo0[6] & cap_q.lo1[6];
  assign t_w_ppn0  = cap_q.lo0[26:7];
  assign t_w_ppn1  = cap_q.lo1[26:7];
  assign t_w_mat0  = cap_q.lo0[5:4];
  assign t_w_mat1  = cap_q.lo1[5:4];
  assign t_w_plv0  = cap_q.lo0[3:2];
  assign t_w_plv1  = cap_q.lo1[3:2];
  assign t_w_d0    = cap_q.lo0[1];
  assign t_w_d1    = cap_q.lo1[1];
  assign t_w_v0    = cap_q.lo0[0];
  assign t_w_v1    = cap_q.lo1[0];

  assign t_r_index  = cap_q.idx;
  assign t_inv_op   = cap_q.iop;
  assign t_inv_asid = cap_q.iasid;
  assign t_inv_vpn  = cap_q.ivpn;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Randomized bench for tlb_ctrl: cycle-indexed expectation schedule
// built at accept time, plus a small TLB stub answering port-1 searches.
module tb_tlb_ctrl;
  localparam int N    = 32;
  localparam int IW   = $clog2(N);
  localparam int NCYC = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic [18:0] csr_vppn;
  logic [9:0] csr_asid;
  logic [IW-1:0] csr_index;
  logic [5:0] csr_ps;
  logic csr_ne, csr_tlbr;
  logic [31:0] csr_elo0, csr_elo1;
  logic [4:0] inv_op;
  logic [9:0] inv_asid;
  logic [18:0] inv_vpn;
  logic mem_req, mem_odd, mem_gnt, mem_rsp_valid;
  logic [18:0] mem_vppn;
  logic [9:0] mem_asid;
  logic t_s1_fetch, t_s1_odd_page, t_s1_found;
  logic [18:0] t_s1_vppn;
  logic [9:0] t_s1_asid;
  logic [4:0] t_s1_index;
  logic t_we, t_w_g, t_w_e;
  logic [IW-1:0] t_w_index, t_r_index;
  logic [18:0] t_w_vppn;
  logic [9:0] t_w_asid;
  logic [5:0] t_w_ps;
  logic t_w_v0, t_w_v1, t_w_d0, t_w_d1;
  logic [1:0] t_w_mat0, t_w_mat1, t_w_plv0, t_w_plv1;
  logic [19:0] t_w_ppn0, t_w_ppn1;
  logic t_inv_en;
  logic [4:0] t_inv_op;
  logic [9:0] t_inv_asid;
  logic [18:0] t_inv_vpn;
  logic csr_srch_we, srch_hit, csr_rd_we;
  logic [IW-1:0] srch_index;

  tlb_ctrl_if opif ();

  tlb_ctrl #(.TLBNUM(N)) dut (
    .clk(clk), .resetn(resetn), .op(opif),
    .csr_vppn(csr_vppn), .csr_asid(csr_asid),
    .csr_index(csr_index), .csr_ps(csr_ps),
    .csr_ne(csr_ne), .csr_tlbr(csr_tlbr),
    .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn),
    .mem_req(mem_req), .mem_vppn(mem_vppn), .mem_odd(mem_odd),
    .mem_asid(mem_asid), .mem_gnt(mem_gnt),
    .mem_rsp_valid(mem_rsp_valid),
    .t_s1_fetch(t_s1_fetch), .t_s1_vppn(t_s1_vppn),
    .t_s1_odd_page(t_s1_odd_page), .t_s1_asid(t_s1_asid),
    .t_s1_found(t_s1_found), .t_s1_index(t_s1_index),
    .t_we(t_we), .t_w_index(t_w_index), .t_w_vppn(t_w_vppn),
    .t_w_asid(t_w_asid), .t_w_g(t_w_g), .t_w_ps(t_w_ps),
    .t_w_e(t_w_e), .t_w_v0(t_w_v0), .t_w_v1(t_w_v1),
    .t_w_d0(t_w_d0), .t_w_d1(t_w_d1),
    .t_w_mat0(t_w_mat0), .t_w_mat1(t_w_mat1),
    .t_w_plv0(t_w_plv0), .t_w_plv1(t_w_plv1),
    .t_w_ppn0(t_w_ppn0), .t_w_ppn1(t_w_ppn1),
    .t_r_index(t_r_index), .t_inv_en(t_inv_en),
    .t_inv_op(t_inv_op), .t_inv_asid(t_inv_asid),
    .t_inv_vpn(t_inv_vpn), .csr_srch_we(csr_srch_we),
    .srch_hit(srch_hit), .srch_index(srch_index),
    .csr_rd_we(csr_rd_we)
  );

  typedef struct {
    bit done, err, we, inv_en, srch_we, rd_we, sreq;
    bit [IW-1:0] widx, ridx;
    bit [18:0] vppn;
    bit [9:0] asid;
    bit [5:0] ps;
    bit e, g;
    bit [19:0] ppn0, ppn1;
    bit [5:0] lo0, lo1;
    bit [4:0] iop;
    bit [9:0] iasid;
    bit [18:0] ivpn;
  } exp_t;

  typedef struct {
    bit [2:0] code;
    bit [18:0] vppn;
    bit [9:0] asid;
    bit [IW-1:0] idx;
    bit [5:0] ps;
    bit ne, tlbr;
    bit [4:0] iop;
    int tag;
  } req_t;

  exp_t sched[int];
  req_t dq[$];
  // [0] = reference TLB contents, [1] = stub fed by DUT write port
  bit me[2][N];
  bit [18:0] mv[2][N];
  bit [9:0] ma[2][N];
  bit mg[2][N];

  int cyc, errs, checks;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  function automatic void look(input int w, input bit [18:0] v,
                               input bit [9:0] a, output bit f,
                               output bit [IW-1:0] ix);
    f = 0;
    ix = '0;
    for (int i = N - 1; i >= 0; i--)
      if (me[w][i] && mv[w][i] == v && (mg[w][i] || ma[w][i] == a)) begin
        f = 1;
        ix = IW'(i);
      end
  endfunction

  function automatic bit [2:0] rand_code();
    int r;
    r = $urandom_range(0, 15);
    if (r < 3) return 3'd0;
    if (r < 5) return 3'd1;
    if (r < 8) return 3'd2;
    if (r < 11) return 3'd3;
    if (r < 14) return 3'd4;
    return 3'($urandom_range(5, 7));
  endfunction

  initial begin
    exp_t z, x, e;
    req_t cur;
    bit pend, f, did_rs;
    bit [IW-1:0] ix;
    bit r_fetch, r_we, r_e, r_g;
    bit [18:0] r_vppn, r_wvppn;
    bit [9:0] r_asid, r_wasid;
    bit [IW-1:0] r_widx;
    bit p_rst, p_req, p_gnt;
    int next_free, fill, rs_c;
    int lit[8];

    errs = 0; checks = 0; next_free = 0; fill = 0;
    pend = 0; did_rs = 0; rs_c = -100;
    r_fetch = 0; r_we = 0; p_rst = 0; p_req = 0; p_gnt = 0;
    r_e = 0; r_g = 0; r_vppn = '0; r_wvppn = '0;
    r_asid = '0; r_wasid = '0; r_widx = '0;
    cur = '{default: 0};
    foreach (lit[i]) lit[i] = -100;
    resetn = 0; opif.op_valid = 0; opif.op_code = '0;
    t_s1_found = 0; t_s1_index = '0;

    dq.push_back('{3'd2, 19'h12345, 10'd3, IW'(5), 6'd12, 0, 0, 5'd0, 1});
    dq.push_back('{3'd0, 19'h12345, 10'd3, IW'(0), 6'd0, 0, 0, 5'd0, 2});
    dq.push_back('{3'd3, 19'h00001, 10'd1, IW'(9), 6'd12, 0, 0, 5'd0, 3});
    dq.push_back('{3'd3, 19'h00002, 10'd1, IW'(9), 6'd12, 0, 0, 5'd0, 4});
    dq.push_back('{3'd3, 19'h00003, 10'd1, IW'(9), 6'd12, 0, 0, 5'd0, 5});
    dq.push_back('{3'd4, 19'h00000, 10'd0, IW'(0), 6'd0, 0, 0, 5'd7, 6});
    dq.push_back('{3'd6, 19'h00000, 10'd0, IW'(0), 6'd0, 0, 0, 5'd0, 7});

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      if (r_fetch) begin
        look(1, r_vppn, r_asid, f, ix);
        t_s1_found = f;
        t_s1_index = 5'(ix);
      end else begin
        t_s1_found = 0;
        t_s1_index = 5'($urandom_range(0, 31));
      end
      if (r_we) begin
        me[1][r_widx] = r_e; mv[1][r_widx] = r_wvppn;
        ma[1][r_widx] = r_wasid; mg[1][r_widx] = r_g;
      end

      if (c < 2) resetn = 0;
      else if (!did_rs && c > 80 && sched.exists(c) && sched[c].sreq) begin
        resetn = 0; did_rs = 1; rs_c = c;
      end
      else if (c > 80 && $urandom_range(0, 99) == 0) resetn = 0;
      else resetn = 1;

      if (!pend && $urandom_range(0, 2) != 0) begin
        if (dq.size() > 0) cur = dq.pop_front();
        else begin
          cur.code = rand_code();
          cur.tag = 0;
        end
        pend = 1;
      end
      csr_vppn  = 19'($urandom_range(0, 7));
      csr_asid  = 10'($urandom_range(0, 3));
      csr_index = IW'($urandom_range(0, N - 1));
      csr_ps    = 6'($urandom_range(0, 63));
      csr_ne    = ($urandom_range(0, 3) == 0);
      csr_tlbr  = ($urandom_range(0, 3) == 0);
      csr_elo0  = $urandom;
      csr_elo1  = $urandom;
      inv_op    = 5'($urandom_range(0, 9));
      inv_asid  = 10'($urandom);
      inv_vpn   = 19'($urandom);
      if (pend && cur.tag != 0) begin
        csr_vppn = cur.vppn; csr_asid = cur.asid; csr_index = cur.idx;
        csr_ps = cur.ps; csr_ne = cur.ne; csr_tlbr = cur.tlbr;
        inv_op = cur.iop;
      end
      opif.op_valid = pend;
      opif.op_code  = pend ? cur.code : 3'($urandom_range(0, 7));
      mem_req  = $urandom_range(0, 1);
      mem_vppn = 19'($urandom);
      mem_odd  = $urandom_range(0, 1);
      mem_asid = 10'($urandom);

      @(negedge clk);
      e = sched.exists(c) ? sched[c] : z;

      chk("op_done", opif.op_done, resetn & e.done);
      chk("op_err", opif.op_err, resetn & e.err);
      chk("t_we", t_we, resetn & e.we);
      chk("t_inv_en", t_inv_en, resetn & e.inv_en);
      chk("csr_srch_we", csr_srch_we, resetn & e.srch_we);
      chk("csr_rd_we", csr_rd_we, resetn & e.rd_we);
      chk("t_s1_fetch", t_s1_fetch, resetn & (e.sreq | mem_req));
      if (c >= 1) begin
        chk("mem_gnt", mem_gnt, !e.sreq);
        chk("t_s1_vppn", t_s1_vppn, e.sreq ? e.vppn : mem_vppn);
        chk("t_s1_asid", t_s1_asid, e.sreq ? e.asid : mem_asid);
        chk("t_s1_odd", t_s1_odd_page, !e.sreq & mem_odd);
        chk("mem_rsp_valid", mem_rsp_valid, p_rst & p_req & p_gnt);
      end
      if (resetn && c >= 2) chk("op_ready", opif.op_ready, c >= next_free);
      if (resetn && e.we) begin
        chk("w_index", t_w_index, e.widx);
        chk("w_vppn", t_w_vppn, e.vppn);
        chk("w_asid", t_w_asid, e.asid);
        chk("w_ps", t_w_ps, e.ps);
        chk("w_e", t_w_e, e.e);
        chk("w_g", t_w_g, e.g);
        chk("w_ppn0", t_w_ppn0, e.ppn0);
        chk("w_ppn1", t_w_ppn1, e.ppn1);
        chk("w_lo0", {t_w_mat0, t_w_plv0, t_w_d0, t_w_v0}, e.lo0);
        chk("w_lo1", {t_w_mat1, t_w_plv1, t_w_d1, t_w_v1}, e.lo1);
      end
      if (resetn && e.rd_we) chk("r_index", t_r_index, e.ridx);
      if (resetn && e.inv_en)
        chk("inv_ops", {t_inv_op, t_inv_asid, t_inv_vpn},
            {e.iop, e.iasid, e.ivpn});
      if (resetn && e.srch_we) begin
        look(0, e.vppn, e.asid, f, ix);
        chk("srch_hit", srch_hit, f);
        chk("srch_index", srch_index, ix);
      end

      if (c == 2) begin
        chk("lit_rst_ready", opif.op_ready, 1);
        chk("lit_rst_gnt", mem_gnt, 1);
      end
      if (c == lit[1] + 1) begin
        chk("lit_wr_idx", t_w_index, 5);
        chk("lit_wr_e", t_w_e, 1);
      end
      if (c == lit[2] + 2) begin
        chk("lit_srch_hit", srch_hit, 1);
        chk("lit_srch_idx", srch_index, 5);
      end
      for (int k = 3; k <= 5; k++)
        if (c == lit[k] + 1) chk("lit_fill_idx", t_w_index, k - 3);
      for (int k = 6; k <= 7; k++)
        if (c == lit[k] + 1)
          chk("lit_illegal", {opif.op_done, opif.op_err, t_inv_en}, 3'b110);
      if (c == rs_c + 1) begin
        chk("lit_rst_srch_we", csr_srch_we, 0);
        chk("lit_rst_ready2", opif.op_ready, 1);
      end

      if (resetn && e.we) begin
        me[0][e.widx] = e.e; mv[0][e.widx] = e.vppn;
        ma[0][e.widx] = e.asid; mg[0][e.widx] = e.g;
      end
      if (!resetn) begin
        for (int k = 1; k <= 3; k++) sched.delete(c + k);
        next_free = c + 1;
        fill = 0;
      end else if (opif.op_valid && c >= next_free) begin
        x = z;
        case (opif.op_code)
          3'd0: begin
            x.sreq = 1; x.vppn = csr_vppn; x.asid = csr_asid;
            sched[c + 1] = x;
            x.sreq = 0; x.srch_we = 1; x.done = 1;
            sched[c + 2] = x;
            next_free = c + 3;
          end
          3'd1: begin x.rd_we = 1; x.ridx = csr_index; end
          3'd2, 3'd3: begin
            x.we = 1;
            x.widx = (opif.op_code == 3'd2) ? csr_index : IW'(fill);
            if (opif.op_code == 3'd3) fill = (fill + 1) % N;
            x.vppn = csr_vppn; x.asid = csr_asid; x.ps = csr_ps;
            x.e = csr_tlbr | !csr_ne;
            x.g = csr_elo0[6] & csr_elo1[6];
            x.ppn0 = csr_elo0[27:8]; x.ppn1 = csr_elo1[27:8];
            x.lo0 = csr_elo0[5:0]; x.lo1 = csr_elo1[5:0];
          end
          3'd4: begin
            if (inv_op <= 5'd6) begin
              x.inv_en = 1; x.iop = inv_op;
              x.iasid = inv_asid; x.ivpn = inv_vpn;
            end else x.err = 1;
          end
          default: x.err = 1;
        endcase
        if (opif.op_code != 3'd0) begin
          x.done = 1;
          sched[c + 1] = x;
          next_free = c + 2;
        end
        if (cur.tag != 0) lit[cur.tag] = c;
        pend = 0;
      end
      sched.delete(c);

      p_rst = resetn; p_req = mem_req; p_gnt = !e.sreq;
      r_fetch = t_s1_fetch; r_vppn = t_s1_vppn; r_asid = t_s1_asid;
      r_we = t_we; r_widx = t_w_index; r_e = t_w_e; r_g = t_w_g;
      r_wvppn = t_w_vppn; r_wasid = t_w_asid;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/tlb_ctrl.md
# tlb_ctrl

Sequencer and port arbiter in front of the 32-entry `tlb_entry` array. It executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB, one at a time, from a valid/ready op interface. It shares search port 1 between TLBSRCH and data-side (MEM-stage) address translation. Operands are captured from the CSR file at accept, and results are returned to the CSR file as one-cycle write strobes.

## Interface
- `TLBNUM`, 32, number of TLB entries; `IDXW` = $clog2(TLBNUM)
- `clk`  in  1  clock
- `resetn`  in  1  synchronous, active-low reset
- `op_valid`  in  1  op request; `op_code`  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5–7 illegal
- `op_ready`  out  1  high only in IDLE; `op_done`  out  1  one-cycle completion pulse; `op_err`  out  1  pulses with `op_done` for illegal op_code or inv_op
- `csr_vppn` in 19, `csr_asid` in 10, `csr_index` in IDXW, `csr_ps` in 6, `csr_ne` in 1, `csr_tlbr` in 1  TLBEHI/ASID/TLBIDX fields and refill-exception flag
- `csr_elo0`, `csr_elo1`  in  32  TLBELO layout: [0] V, [1] D, [3:2] PLV, [5:4] MAT, [6] G, [27:8] PPN
- `inv_op` in 5, `inv_asid` in 10, `inv_vpn` in 19  INVTLB operands
- `mem_req` in 1, `mem_vppn` in 19, `mem_odd` in 1, `mem_asid` in 10  data-side search request; `mem_gnt` out 1; `mem_rsp_valid` out 1
- `t_s1_fetch` out 1, `t_s1_vppn` out 19, `t_s1_odd_page` out 1, `t_s1_asid` out 10  to TLB search port 1
- `t_s1_found` in 1, `t_s1_index` in 5  registered search result from TLB
- `t_we` out 1, `t_w_index` out IDXW, `t_w_vppn/asid/g/ps/e` out 19/10/1/6/1, `t_w_{v,d,mat,plv,ppn}{0,1}` out 1/1/2/2/20  TLB write port
- `t_r_index`  out  IDXW  TLB read index; CSR file samples the TLB `r_*` outputs on `csr_rd_we`
- `t_inv_en` out 1, `t_inv_op` out 5, `t_inv_asid` out 10, `t_inv_vpn` out 19  TLB invalidate port
- `csr_srch_we` out 1, `srch_hit` out 1, `srch_index` out IDXW  TLBSRCH result strobe; `csr_rd_we`  out  1  TLBRD result strobe

## Operation
- States: IDLE, SRCH_REQ, SRCH_RSP, EXEC.
- **Accept** (IDLE, `op_valid`):
  - Register op_code and every `csr_*` and `inv_*` input.
  - Go to SRCH_REQ for op 0, otherwise to EXEC.
  - `op_valid` while not IDLE is ignored and must be held by the requester.
- **SRCH_REQ:** `t_s1_fetch`=1 with the captured vppn/asid; `t_s1_odd_page`=0; `mem_gnt`=0.
- **SRCH_RSP:**
  - `csr_srch_we`=1, `srch_hit`=`t_s1_found`.
  - `srch_index`=`t_s1_index[IDXW-1:0]` when hit, else 0.
  - `op_done`=1; next state IDLE.
- **EXEC** (one cycle, then IDLE, `op_done`=1):
  - RD: `t_r_index`=captured index; `csr_rd_we`=1.
  - WR: `t_we`=1, `t_w_index`=captured index.
  - FILL: `t_we`=1, `t_w_index`=`fill_ptr`. After the write, `fill_ptr` increments, wrapping TLBNUM-1 → 0.
  - WR and FILL write fields:
    - `t_w_e` = `csr_tlbr` ? 1 : ~`csr_ne`.
    - `t_w_g` = elo0.G & elo1.G.
    - Remaining fields come from captured TLBEHI/TLBIDX/ELO.
  - INV with `inv_op` ≤ 6: `t_inv_en`=1, forward captured operands.
  - INV with `inv_op` > 6: no `t_inv_en`; `op_err`=1.
  - op_code 5–7: no TLB access; `op_err`=1.
- **Port-1 arbitration:**
  - `mem_gnt`=0 in SRCH_REQ, 1 in every other state.
  - When granted, the `t_s1_*` outputs carry the `mem_*` inputs and `t_s1_fetch`=`mem_req`.
  - `mem_rsp_valid` is registered (`mem_req` & `mem_gnt`) and marks the cycle in which `t_s1_*` results belong to the data side.
- A mem search issued in the same cycle as a WR/FILL/INV sees pre-write contents.

## Timing
- Reset (`resetn`=0 at posedge):
  - State IDLE, `fill_ptr`=0, all captured registers 0.
  - All strobes 0: `op_done`, `op_err`, `t_we`, `t_inv_en`, `t_s1_fetch`, `csr_srch_we`, `csr_rd_we`, `mem_rsp_valid`.
  - `op_ready`=1, `mem_gnt`=1.
  - Reset mid-op aborts the op: no write, no invalidate, no done.
- Op latency from accept cycle T:
  - SRCH: `op_done` at T+2.
  - RD/WR/FILL/INV/illegal: `op_done` at T+1.
  - Next accept is possible at the cycle after `op_done`.
- TLB write and invalidate take effect at the end of the EXEC cycle.
- All op-driven outputs are registered state decodes. The `t_s1_*` mux is combinational on state.

## Test plan
- Reset: `resetn`=0 for 2 cycles → `op_ready`=1, `mem_gnt`=1, all strobes 0, `fill_ptr`=0.
- WR to index 5 (vppn 0x12345, ps 12, ne=0), then SRCH with vppn 0x12345 → `t_we` pulse at T+1 with index 5, `e`=1; SRCH result `srch_hit`=1, `srch_index`=5 at T+2.
- Three FILLs in sequence → `t_w_index` = 0, 1, 2. With TLBNUM=4, the fifth FILL → index 0.
- `mem_req` held high during SRCH → `mem_gnt`=0 only in SRCH_REQ; `mem_rsp_valid` low the cycle after SRCH_REQ and high in other cycles.
- INV `inv_op`=7 → `op_done`=1 and `op_err`=1 at T+1, `t_inv_en` stays 0. `op_code`=6 → same response.
- `resetn` low in SRCH_REQ → no `csr_srch_we`; IDLE next cycle. WR where `csr_elo0` changes after accept → written PPN equals the value captured at accept.
